// File: rtl/vga_pkg.sv
// Shared VGA definitions used by both the capture block and the transmitter:
// nominal 640x480 timing totals, the RGB332 pixel type and the capture FSM states.
package vga_pkg;

   localparam int H_TOTAL = 800;
   localparam int V_TOTAL = 525;

   typedef struct packed {
      logic [2:0] red;
      logic [2:0] green;
      logic [1:0] blue;
   } rgb332_t;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } cap_state_t;

   function automatic rgb332_t pack_rgb(input logic [2:0] r, input logic [2:0] g,
                                        input logic [1:0] b);
      rgb332_t p;
      p.red   = r;
      p.green = g;
      p.blue  = b;
      return p;
   endfunction

endpackage

// File: rtl/vga_capture_sync_edge.sv
// Registers one active-low sync input on the pixel strobe and flags its rising edge
// (previous sample low, current input high) on that same strobe.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic pix_en,
   input  logic sync_in,
   output logic rise
);
   import vga_pkg::*;

   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 1'b1;
      end else if (pix_en) begin
         sync_q <= sync_in;
      end
   end

   assign rise = pix_en & ~sync_q & sync_in;

endmodule

// File: rtl/vga_capture.sv
// Measures incoming VGA line/frame timing, locks when it is stable and emits
// one write strobe per visible pixel with its column, row and RGB332 value.
//
//   state   | meaning
//   SEARCH  | no timing reference; waiting for a VS rising edge
//   MEASURE | checking one frame for constant line length and enough lines
//   LOCKED  | timing stable; visible pixels are written out
module vga_capture #(
   parameter int H_BEGIN  = 48,
   parameter int H_ACTIVE = 640,
   parameter int V_BEGIN  = 0,
   parameter int V_ACTIVE = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       HS,
   input  logic       VS,
   input  logic [2:0] red,
   input  logic [2:0] green,
   input  logic [1:0] blue,
   output logic       wr_en,
   output logic [9:0] wr_x,
   output logic [8:0] wr_y,
   output logic [7:0] wr_data,
   output logic       locked,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines,
   output logic       frame_done,
   output logic       err
);
   import vga_pkg::*;

   cap_state_t  state;
   logic        hs_rise, vs_rise;
   logic [9:0]  hc, vc, ref_len;
   logic        have_ref, len_ok;
   logic        h_sat, v_sat, frame_good, in_win, wr_fire;
   logic [10:0] x_off, y_off;

   sync_edge u_hs (.clk(clk), .reset(reset), .pix_en(pix_en), .sync_in(HS), .rise(hs_rise));
   sync_edge u_vs (.clk(clk), .reset(reset), .pix_en(pix_en), .sync_in(VS), .rise(vs_rise));

   assign h_sat = (hc == 10'h3FF);
   assign v_sat = (vc == 10'h3FF);

   // Offsets wrap to >= 1024 when the counter is before the window start,
   // so a single unsigned compare covers both window bounds.
   assign x_off  = {1'b0, hc} - 11'(H_BEGIN);
   assign y_off  = {1'b0, vc} - 11'(V_BEGIN);
   assign in_win = (x_off < 11'(H_ACTIVE)) && (y_off < 11'(V_ACTIVE));

   // The line ending on this VS edge counts toward the frame; the line count
   // checked is the one latched at the previous VS edge.
   assign frame_good = have_ref && len_ok && (!hs_rise || (hc == ref_len)) &&
                       ({1'b0, frame_lines} > 11'(V_BEGIN + V_ACTIVE - 1));

   assign wr_fire = pix_en && (state == LOCKED) && in_win;
   assign locked  = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         hc          <= '0;
         vc          <= '0;
         line_len    <= '0;
         frame_lines <= '0;
      end else if (pix_en) begin
         if (hs_rise) begin
            hc       <= '0;
            line_len <= hc;
         end else if (!h_sat) begin
            hc <= hc + 10'd1;
         end
         if (vs_rise) begin
            vc          <= '0;
            frame_lines <= vc;
         end else if (hs_rise && !v_sat) begin
            vc <= vc + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         have_ref <= 1'b0;
         len_ok   <= 1'b1;
         ref_len  <= '0;
      end else if (vs_rise) begin
         have_ref <= 1'b0;
         len_ok   <= 1'b1;
      end else if (hs_rise) begin
         if (!have_ref) begin
            ref_len  <= hc;
            have_ref <= 1'b1;
         end else if (hc != ref_len) begin
            len_ok <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEARCH;
         err   <= 1'b0;
      end else if (h_sat || v_sat) begin
         state <= SEARCH;
         err   <= 1'b1;
      end else begin
         case (state)
            SEARCH:  if (vs_rise) state <= MEASURE;
            MEASURE: if (vs_rise && frame_good) state <= LOCKED;
            LOCKED: begin
               if (hs_rise && (hc != line_len)) begin
                  state <= SEARCH;
                  err   <= 1'b1;
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en      <= 1'b0;
         wr_x       <= '0;
         wr_y       <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
      end else begin
         wr_en      <= wr_fire;
         frame_done <= vs_rise && (state == LOCKED);
         if (wr_fire) begin
            wr_x    <= x_off[9:0];
            wr_y    <= y_off[8:0];
            wr_data <= pack_rgb(red, green, blue);
         end
      end
   end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_BEGIN, default 48: pixel clocks after the HS rising edge to the first visible pixel.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter V_BEGIN, default 0: lines after the VS rising edge to the first visible line.
REQ-004 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pix_en  in  1  one-clk pixel strobe; all sampling and counting occurs only on clk edges where pix_en=1.
REQ-008 HS  in  1  horizontal sync, active low.
REQ-009 VS  in  1  vertical sync, active low.
REQ-010 red/green/blue  in  3/3/2  pixel colour.
REQ-011 wr_en  out  1  one-clk pixel write strobe.
REQ-012 wr_x  out  10  column 0..H_ACTIVE-1.
REQ-013 wr_y  out  9  row 0..V_ACTIVE-1.
REQ-014 wr_data  out  8  {red,green,blue}.
REQ-015 locked  out  1  timing stable; writes enabled.
REQ-016 line_len  out  10  last measured HS period in pixels, minus 1.
REQ-017 frame_lines  out  10  last measured lines per frame, minus 1.
REQ-018 frame_done  out  1  one-clk pulse on each VS rising edge while locked.
REQ-019 err  out  1  sticky flag: lock lost or counter overflow; cleared only by reset.

Function
REQ-020 HS and VS are registered on pix_en into hs_q/vs_q; a rising edge is hs_q=0 and HS=1 sampled on the same pix_en.
REQ-021 hc (10 bits) loads 0 on an HS rising edge and increments on every other pix_en; line_len captures hc on that edge.
REQ-022 vc (10 bits) increments on each HS rising edge and loads 0 on a VS rising edge; frame_lines captures vc on that edge.
REQ-023 When HS and VS rising edges coincide, hc←0 and vc←0; the line increment is discarded.
REQ-024 hc or vc reaching 1023 forces state SEARCH, sets err, and holds the counter at 1023 until the next corresponding edge.
REQ-025 FSM states: SEARCH, MEASURE, LOCKED.
REQ-026 SEARCH→MEASURE on a VS rising edge.
REQ-027 MEASURE→LOCKED on the next VS rising edge when every line_len captured during that frame equals the first one and frame_lines exceeds V_BEGIN+V_ACTIVE-1; otherwise remain in MEASURE.
REQ-028 LOCKED→SEARCH, setting err, on any HS rising edge whose hc differs from line_len.
REQ-029 Pixel window: H_BEGIN ≤ hc < H_BEGIN+H_ACTIVE and V_BEGIN ≤ vc < V_BEGIN+V_ACTIVE; wr_x=hc-H_BEGIN, wr_y=vc-V_BEGIN, truncated to port width.
REQ-030 In LOCKED with the pixel window true on a pix_en, the next clk drives wr_en=1 with wr_x, wr_y, and wr_data of that sample (latency 1 clk); wr_en=0 on all other cycles.
REQ-031 wr_x/wr_y/wr_data hold their last values while wr_en=0.
REQ-032 locked=1 exactly when state is LOCKED.

Reset
REQ-033 On reset: state=SEARCH; hc, vc, line_len, frame_lines, wr_x, wr_y, wr_data = 0; hs_q=vs_q=1; wr_en, locked, frame_done, err = 0.
REQ-034 Reset asserted mid-frame takes effect on the same clk edge; no write strobe issues in the following cycle.

Structure
REQ-035 A shared package vga_pkg holds the 800/525 timing constants, the 8-bit RGB332 pixel type, and the FSM state enum; the VGA transmitter uses the same package.
REQ-036 One sub-module, sync_edge (register plus rising-edge detect gated by pix_en), is instantiated once for HS and once for VS.

Verification
REQ-037 800×525 source (HS low at hc 704..799, VS low at lines 523..524), pix_en every 4th clk -> locked=1 at the third VS rise; line_len=799, frame_lines=524.
REQ-038 Locked frame with pixel (x=0,y=0)=8'hE0 and (639,479)=8'h1F -> exactly 307200 wr_en pulses per frame, first carrying (0,0,E0), last (639,479,1F), each 1 clk after the sampling pix_en.
REQ-039 While locked, one line shortened to 799 pixels -> locked drops on that HS rise, err=1, no further writes until relock.
REQ-040 HS held high for 1100 pix_en -> hc saturates at 1023, state SEARCH, err=1, wr_en stays 0.
REQ-041 Reset pulsed at hc=300 of line 100 -> all outputs at reset values on the next clk; relock after two more full frames.
REQ-042 HS and VS rising on the same pix_en -> hc=0 and vc=0 on the next clk, frame_lines holds the prior vc, no extra line counted.
